pipe_hazard_unit: RTL

- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It sits beside the ID stage decoder.
- Adds three things to operand forwarding and load-use detection:
  - a multi-cycle multiply/divide (MD) busy scoreboard,
  - a whole-pipe freeze for variable-latency data memory,
  - a saturating stall-cycle performance counter.
- The decoder supplies per-instruction use/issue flags. This block returns forwarding selects, stall, bubble, freeze and flush controls.

---
 rtl/pipe_hazard_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: operand forwarding,
// load-use and multiply/divide interlocks, data-memory freeze and a stall-cycle counter.
module pipe_hazard_unit #(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16,
   localparam int MD_W  = $clog2(MD_LAT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_use,
   input  logic              id_rt_use,
   input  logic              id_is_md,
   input  logic              id_uses_hilo,
   input  logic              redirect,
   input  logic              ex_wreg,
   input  logic              ex_m2reg,
   input  logic [REG_AW-1:0] ex_wr,
   input  logic              mem_wreg,
   input  logic              mem_m2reg,
   input  logic [REG_AW-1:0] mem_wr,
   input  logic              mem_ready,
   input  logic              stall_cnt_clr,
   output logic [1:0]        fwda,
   output logic [1:0]        fwdb,
   output logic              stall_if,
   output logic              bubble_ex,
   output logic              freeze,
   output logic              flush_if,
   output logic              md_busy,
   output logic [MD_W-1:0]   md_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [MD_W-1:0]  md_cnt_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             lu_haz_s;
   logic             md_haz_s;
   logic             md_issue_s;

   // EX results beat MEM results; register 0 is hardwired and never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              src_use,
      input logic              exw,
      input logic              exm,
      input logic [REG_AW-1:0] exr,
      input logic              mw,
      input logic              mm,
      input logic [REG_AW-1:0] mr
   );
      logic ex_hit;
      logic mem_hit;
      ex_hit  = src_use && exw && (exr != {REG_AW{1'b0}}) && (exr == src);
      mem_hit = src_use && mw && (mr != {REG_AW{1'b0}}) && (mr == src);
      if (ex_hit && !exm) begin
         return 2'b01;
      end else if (mem_hit && !mm) begin
         return 2'b10;
      end else if (mem_hit && mm) begin
         return 2'b11;
      end else begin
         return 2'b00;
      end
   endfunction

   // Hazard detection and pipeline control decode.
   always_comb begin
      fwda       = fwd_sel(id_rs, id_rs_use, ex_wreg, ex_m2reg, ex_wr, mem_wreg, mem_m2reg, mem_wr);
      fwdb       = fwd_sel(id_rt, id_rt_use, ex_wreg, ex_m2reg, ex_wr, mem_wreg, mem_m2reg, mem_wr);
      md_busy    = (md_cnt_r != {MD_W{1'b0}});
      lu_haz_s   = id_valid && ex_wreg && ex_m2reg && (ex_wr != {REG_AW{1'b0}}) &&
                   ((id_rs_use && (ex_wr == id_rs)) || (id_rt_use && (ex_wr == id_rt)));
      md_haz_s   = id_valid && md_busy && (id_is_md || id_uses_hilo);
      freeze     = mem_m2reg && !mem_ready;
      stall_if   = freeze || md_haz_s || lu_haz_s;
      // A frozen pipe must not also swallow the ID instruction; the hazard is re-seen afterwards.
      bubble_ex  = !freeze && (md_haz_s || lu_haz_s);
      flush_if   = redirect && id_valid && !stall_if;
      md_issue_s = id_valid && id_is_md && !stall_if;
      md_cnt     = md_cnt_r;
      stall_cnt  = stall_cnt_r;
   end

   // MD busy countdown (keeps running through freezes) and saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt_r    <= {MD_W{1'b0}};
         stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (md_issue_s) begin
            md_cnt_r <= MD_W'(MD_LAT);
         end else if (md_cnt_r != {MD_W{1'b0}}) begin
            md_cnt_r <= md_cnt_r - {{(MD_W-1){1'b0}}, 1'b1};
         end else begin
            md_cnt_r <= md_cnt_r;
         end

         if (stall_cnt_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
         end else if (stall_if && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

endmodule
